// File: rtl/shift_line_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_line_ctrl_if
// Requester and emerge-side signals of the shift-line controller.
//   req0_valid/req0_data/req0_ready : requester 0 valid/ready stream
//   req1_valid/req1_data/req1_ready : requester 1 valid/ready stream
//   out_valid/out_data/out_tag      : word emerging from the line with its tag
// slave  : controller view (takes requests, produces ready and emerged words)
// master : environment view (drives requests, observes ready and emerged words)
// -----------------------------------------------------------------------------
interface shift_line_ctrl_if #(
    parameter int unsigned W = 4
);
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_tag;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, out_valid, out_data, out_tag
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/shift_line_ctrl.sv
// -----------------------------------------------------------------------------
// shift_line_ctrl
// Controller for a DEPTH-stage, W-bit shift-enable delay line. Arbitrates two
// requesters round-robin onto the line, tracks a valid bit and requester tag
// per stage, captures words emerging at so, and drains the line with bubbles on
// flush or after IDLE_TIMEOUT idle cycles (0 disables auto-drain).
// Ports:
//   clk, rst_n  : clock (shared with the line), async active-low reset
//   bus         : requester streams and emerged-word outputs (slave modport)
//   flush       : request to drain every valid word from the line
//   shn, si     : shift enable and serial input to the line (combinational)
//   so          : last stage of the line
//   occupancy   : number of valid words in the line
//   busy        : high while draining
//   flush_done  : one-cycle pulse when a drain completes
// -----------------------------------------------------------------------------
module shift_line_ctrl #(
    parameter int unsigned W            = 4,
    parameter int unsigned DEPTH        = 9,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    shift_line_ctrl_if.slave             bus,
    input  logic                         flush,
    output logic                         shn,
    output logic [W-1:0]                 si,
    input  logic [W-1:0]                 so,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         busy,
    output logic                         flush_done
);

    localparam int unsigned OW      = $clog2(DEPTH + 1);
    localparam int unsigned CW      = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam int unsigned TO_M1   = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;
    localparam bit          TO_EN   = (IDLE_TIMEOUT > 0);

    localparam logic [0:0]  ST_RUN   = 1'b0;
    localparam logic [0:0]  ST_DRAIN = 1'b1;

    logic [0:0]       state_q,      state_d;
    logic [DEPTH-1:0] vld_q,        vld_d;
    logic [DEPTH-1:0] tag_q,        tag_d;
    logic             rr_q,         rr_d;
    logic [CW-1:0]    idle_cnt_q,   idle_cnt_d;
    logic [OW-1:0]    occ_q,        occ_d;
    logic             out_valid_q,  out_valid_d;
    logic [W-1:0]     out_data_q,   out_data_d;
    logic             out_tag_q,    out_tag_d;
    logic             busy_q,       busy_d;
    logic             flush_done_q, flush_done_d;

    logic             grant0_c;
    logic             grant1_c;
    logic             accept_c;
    logic             shn_c;
    logic [W-1:0]     si_c;
    logic             emerge_c;

    // State and bookkeeping registers; the line itself lives outside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            vld_q        <= '0;
            tag_q        <= '0;
            rr_q         <= 1'b0;
            idle_cnt_q   <= '0;
            occ_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= 1'b0;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            tag_q        <= tag_d;
            rr_q         <= rr_d;
            idle_cnt_q   <= idle_cnt_d;
            occ_q        <= occ_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            busy_q       <= busy_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Next-state, arbitration and line-drive logic.
    always_comb begin
        state_d      = state_q;
        vld_d        = vld_q;
        tag_d        = tag_q;
        rr_d         = rr_q;
        idle_cnt_d   = idle_cnt_q;
        occ_d        = occ_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        flush_done_d = 1'b0;
        grant0_c     = 1'b0;
        grant1_c     = 1'b0;
        accept_c     = 1'b0;
        shn_c        = 1'b0;
        si_c         = '0;
        emerge_c     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (!flush) begin
                    // rr_q=0 favours requester 0 under contention
                    if (bus.req0_valid && (!bus.req1_valid || !rr_q)) begin
                        grant0_c = 1'b1;
                    end else if (bus.req1_valid) begin
                        grant1_c = 1'b1;
                    end
                    if (bus.req0_valid && bus.req1_valid) begin
                        rr_d = grant0_c;
                    end
                end
                accept_c = grant0_c | grant1_c;
                shn_c    = accept_c;
                si_c     = grant1_c ? bus.req1_data : (grant0_c ? bus.req0_data : '0);

                if (flush) begin
                    if (occ_q != '0) begin
                        state_d    = ST_DRAIN;
                        idle_cnt_d = '0;
                    end else begin
                        flush_done_d = 1'b1;
                    end
                end else if (accept_c) begin
                    idle_cnt_d = '0;
                end else if (TO_EN && (occ_q != '0)) begin
                    if (idle_cnt_q == CW'(TO_M1)) begin
                        state_d    = ST_DRAIN;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CW'(1);
                    end
                end
            end

            ST_DRAIN: begin
                shn_c = 1'b1;
                si_c  = '0;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        emerge_c = shn_c & vld_q[DEPTH-1];

        // Valid/tag track the line stage for stage; a bubble enters while draining.
        if (shn_c) begin
            vld_d = {vld_q[DEPTH-2:0], accept_c};
            tag_d = {tag_q[DEPTH-2:0], grant1_c};
        end

        occ_d = occ_q + OW'(accept_c) - OW'(emerge_c);

        if (emerge_c) begin
            out_valid_d = 1'b1;
            out_data_d  = so;
            out_tag_d   = tag_q[DEPTH-1];
        end

        if ((state_q == ST_DRAIN) && (occ_d == '0)) begin
            state_d      = ST_RUN;
            flush_done_d = 1'b1;
        end

        busy_d = (state_d == ST_DRAIN);
    end

    assign bus.req0_ready = grant0_c;
    assign bus.req1_ready = grant1_c;
    assign shn            = shn_c;
    assign si             = si_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_tag    = out_tag_q;
    assign occupancy      = occ_q;
    assign busy           = busy_q;
    assign flush_done     = flush_done_q;

endmodule
